lcd_cmd_ctrl: RTL and testbench

LCD_CMD_CTRL -- requirements
Module: lcd_cmd_ctrl

---
 rtl/lcd_cmd_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_lcd_cmd_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_cmd_ctrl.sv
// lcd_cmd_ctrl: write-only HD44780 command sequencer driven by a processor register.
// A request is a toggle of lcd_reg_i[30]. Each command runs SETUP -> PULSE -> HOLD -> WAIT.
// A single-entry pending buffer absorbs one request made while busy. Further requests are
// dropped, and each drop sets the sticky ovf_o flag.
// Optional macro LCD_INIT_EN: after reset, wait PWR_CYC clocks, then send the init sequence
// 0x38, 0x0C, 0x01, 0x06 with no acks.
// Ports:
//   clk_i       clock, rising edge
//   rst_i       synchronous active-high reset
//   lcd_reg_i   [31] ON, [30] REQ toggle, [9] RS, [7:0] DATA
//   lcd_on_o    registered ON bit
//   lcd_en_o    EN strobe, high only in PULSE
//   lcd_rs_o    register select of the command in flight
//   lcd_rw_o    tied 0
//   lcd_data_o  bus data of the command in flight
//   busy_o      command in flight or pending
//   ack_o       toggles once per completed user command
//   ovf_o       sticky overrun flag
module lcd_cmd_ctrl #(
    parameter int unsigned SETUP_CYC = 4,
    parameter int unsigned EN_CYC    = 12,
    parameter int unsigned HOLD_CYC  = 4,
    parameter int unsigned EXEC_CYC  = 2000,
    parameter int unsigned LONG_CYC  = 80000,
    parameter int unsigned PWR_CYC   = 1000000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] lcd_reg_i,
    output logic        lcd_on_o,
    output logic        lcd_en_o,
    output logic        lcd_rs_o,
    output logic        lcd_rw_o,
    output logic [7:0]  lcd_data_o,
    output logic        busy_o,
    output logic        ack_o,
    output logic        ovf_o
);
    localparam int unsigned Max1   = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
    localparam int unsigned Max2   = (Max1 > HOLD_CYC) ? Max1 : HOLD_CYC;
    localparam int unsigned Max3   = (Max2 > EXEC_CYC) ? Max2 : EXEC_CYC;
    localparam int unsigned Max4   = (Max3 > LONG_CYC) ? Max3 : LONG_CYC;
    localparam int unsigned MaxCyc = (Max4 > PWR_CYC) ? Max4 : PWR_CYC;
    localparam int unsigned CntW   = $clog2(MaxCyc + 1);

    typedef enum logic [2:0] {
        StIdle, StSetup, StPulse, StHold, StWait
`ifdef LCD_INIT_EN
        , StPwr
`endif
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            tog_q, on_q, busy_q, busy_d;
    logic            rs_q, rs_d, pend_q, pend_d, pend_rs_q, pend_rs_d;
    logic [7:0]      data_q, data_d, pend_data_q, pend_data_d;
    logic            ack_q, ack_d, ovf_q, ovf_d;
    logic            req, req_taken, try_next, launch, launch_rs, long_wait;
    logic [7:0]      launch_data;
    logic            unused_bits;

`ifdef LCD_INIT_EN
    logic       init_q, init_d;
    logic [1:0] idx_q, idx_d;

    function automatic logic [7:0] init_byte(input logic [1:0] i);
        unique case (i)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction
`endif

    assign unused_bits = ^{lcd_reg_i[29:10], lcd_reg_i[8]};
    assign req         = lcd_reg_i[30] ^ tog_q;
    assign long_wait   = !rs_q && ((data_q == 8'h01) || (data_q == 8'h02));

    always_comb begin
        state_d     = state_q;
        cnt_d       = (cnt_q != '0) ? cnt_q - CntW'(1) : cnt_q;
        rs_d        = rs_q;
        data_d      = data_q;
        pend_d      = pend_q;
        pend_rs_d   = pend_rs_q;
        pend_data_d = pend_data_q;
        ack_d       = ack_q;
        ovf_d       = ovf_q;
        req_taken   = 1'b0;
        try_next    = 1'b0;
        launch      = 1'b0;
        launch_rs   = rs_q;
        launch_data = data_q;
`ifdef LCD_INIT_EN
        init_d      = init_q;
        idx_d       = idx_q;
`endif
        unique case (state_q)
            StIdle:  try_next = 1'b1;
            StSetup: if (cnt_q == '0) begin
                state_d = StPulse;
                cnt_d   = CntW'(EN_CYC - 1);
            end
            StPulse: if (cnt_q == '0) begin
                state_d = StHold;
                cnt_d   = CntW'(HOLD_CYC - 1);
            end
            StHold: if (cnt_q == '0) begin
                state_d = StWait;
                cnt_d   = long_wait ? CntW'(LONG_CYC - 1) : CntW'(EXEC_CYC - 1);
            end
            StWait: if (cnt_q == '0) begin
                state_d = StIdle;
`ifdef LCD_INIT_EN
                if (init_q && (idx_q != 2'd3)) begin
                    launch      = 1'b1;
                    launch_rs   = 1'b0;
                    launch_data = init_byte(idx_q + 2'd1);
                    idx_d       = idx_q + 2'd1;
                end else begin
                    if (init_q) init_d = 1'b0;
                    else        ack_d  = ~ack_q;
                    try_next = 1'b1;
                end
`else
                ack_d    = ~ack_q;
                try_next = 1'b1;
`endif
            end
`ifdef LCD_INIT_EN
            StPwr: if (cnt_q == '0) begin
                launch      = 1'b1;
                launch_rs   = 1'b0;
                launch_data = init_byte(2'd0);
                init_d      = 1'b1;
                idx_d       = 2'd0;
            end
`endif
            default: state_d = StIdle;
        endcase

        // Pending entry wins over a fresh request; a request seen on the same clock as a
        // WAIT exit with an empty buffer starts directly, so no idle bubble is inserted.
        if (try_next) begin
            if (pend_q) begin
                launch      = 1'b1;
                launch_rs   = pend_rs_q;
                launch_data = pend_data_q;
                pend_d      = 1'b0;
            end else if (req) begin
                launch      = 1'b1;
                launch_rs   = lcd_reg_i[9];
                launch_data = lcd_reg_i[7:0];
                req_taken   = 1'b1;
            end
        end

        if (launch) begin
            state_d = StSetup;
            cnt_d   = CntW'(SETUP_CYC - 1);
            rs_d    = launch_rs;
            data_d  = launch_data;
        end

        // The buffer counts as full for the whole clock in which it holds an entry.
        if (req && !req_taken) begin
            if (pend_q) begin
                ovf_d = 1'b1;
            end else begin
                pend_d      = 1'b1;
                pend_rs_d   = lcd_reg_i[9];
                pend_data_d = lcd_reg_i[7:0];
            end
        end

        busy_d = (state_d != StIdle) || pend_d;
    end

    always_ff @(posedge clk_i) begin
        // Tracks the toggle bit even in reset, so release never looks like a request.
        tog_q <= lcd_reg_i[30];
        if (rst_i) begin
`ifdef LCD_INIT_EN
            state_q <= StPwr;
            cnt_q   <= CntW'(PWR_CYC - 1);
            init_q  <= 1'b0;
            idx_q   <= 2'd0;
`else
            state_q <= StIdle;
            cnt_q   <= '0;
`endif
            on_q        <= 1'b0;
            busy_q      <= 1'b0;
            rs_q        <= 1'b0;
            data_q      <= 8'h00;
            pend_q      <= 1'b0;
            pend_rs_q   <= 1'b0;
            pend_data_q <= 8'h00;
            ack_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
`ifdef LCD_INIT_EN
            init_q <= init_d;
            idx_q  <= idx_d;
`endif
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            on_q        <= lcd_reg_i[31];
            busy_q      <= busy_d;
            rs_q        <= rs_d;
            data_q      <= data_d;
            pend_q      <= pend_d;
            pend_rs_q   <= pend_rs_d;
            pend_data_q <= pend_data_d;
            ack_q       <= ack_d;
            ovf_q       <= ovf_d;
        end
    end

    assign lcd_on_o   = on_q;
    assign lcd_en_o   = (state_q == StPulse);
    assign lcd_rs_o   = rs_q;
    assign lcd_rw_o   = 1'b0;
    assign lcd_data_o = data_q;
    assign busy_o     = busy_q;
    assign ack_o      = ack_q;
    assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_lcd_cmd_ctrl.sv
// Testbench for lcd_cmd_ctrl (default build, LCD_INIT_EN undefined).
// Stimulus pushes expected commands into a scoreboard queue.
// A negedge monitor checks EN and ack events against that queue.
module tb_lcd_cmd_ctrl;
    localparam int SetupCyc = 2;
    localparam int EnCyc    = 3;
    localparam int HoldCyc  = 2;
    localparam int ExecCyc  = 10;
    localparam int LongCyc  = 40;
    localparam int PwrCyc   = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] reg_v = '0;
    logic        lcd_on, lcd_en, lcd_rs, lcd_rw, busy, ack, ovf;
    logic [7:0]  lcd_data;

    lcd_cmd_ctrl #(
        .SETUP_CYC(SetupCyc),
        .EN_CYC   (EnCyc),
        .HOLD_CYC (HoldCyc),
        .EXEC_CYC (ExecCyc),
        .LONG_CYC (LongCyc),
        .PWR_CYC  (PwrCyc)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .lcd_reg_i (reg_v),
        .lcd_on_o  (lcd_on),
        .lcd_en_o  (lcd_en),
        .lcd_rs_o  (lcd_rs),
        .lcd_rw_o  (lcd_rw),
        .lcd_data_o(lcd_data),
        .busy_o    (busy),
        .ack_o     (ack),
        .ovf_o     (ovf)
    );

    always #5 clk = ~clk;

    // cyc = number of rising edges seen so far
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: event at cycle %0d, none required", name, cyc);
    endtask

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         start;  // edge at which SETUP begins
        int         endc;   // edge at which ack toggles
    } cmd_t;

    cmd_t exp_q[$];

    // Reference model: command timeline
    int m_last_start = 0;
    int m_last_end   = 0;
    bit m_pended     = 0;
    bit m_ovf        = 0;

    function automatic int cmd_len(input logic rs, input logic [7:0] d);
        return SetupCyc + EnCyc + HoldCyc +
               ((!rs && (d == 8'h01 || d == 8'h02)) ? LongCyc : ExecCyc);
    endfunction

    task automatic model_req(input int t, input logic rs, input logic [7:0] d);
        cmd_t c;
        if (m_pended && m_last_start >= t) begin
            m_ovf = 1;
            return;
        end
        c.rs   = rs;
        c.data = d;
        if (m_last_end <= t) begin
            c.start  = t;
            m_pended = 0;
        end else begin
            c.start  = m_last_end;
            m_pended = 1;
        end
        c.endc       = c.start + cmd_len(rs, d);
        m_last_start = c.start;
        m_last_end   = c.endc;
        exp_q.push_back(c);
    endtask

    // Called at a negedge; the toggle is detected at the next rising edge.
    task automatic do_req(input logic rs, input logic [7:0] d);
        logic [31:0] r;
        r = $urandom;
        reg_v[29:10] = r[19:0];
        reg_v[8]     = r[20];
        reg_v[9]     = rs;
        reg_v[7:0]   = d;
        reg_v[30]    = ~reg_v[30];
        model_req(cyc + 1, rs, d);
        @(negedge clk);
        chk("busy_after_req", busy, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) fail_now("drain_timeout");
        repeat (2) @(negedge clk);
        chk("busy_idle", busy, 0);
    endtask

    // Monitor
    bit   mon_en   = 0;
    logic en_prev  = 1'b0;
    logic ack_prev = 1'b0;
    int   rise_cyc = 0;
    int   ack_cnt  = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (lcd_en && !en_prev) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_en");
                end else begin
                    chk("en_rise_time", cyc, exp_q[0].start + SetupCyc);
                    chk("rs_at_rise", lcd_rs, exp_q[0].rs);
                    chk("data_at_rise", lcd_data, exp_q[0].data);
                end
                rise_cyc <= cyc;
            end
            if (!lcd_en && en_prev && exp_q.size() != 0) begin
                chk("en_width", cyc - rise_cyc, EnCyc);
                chk("rs_at_fall", lcd_rs, exp_q[0].rs);
                chk("data_at_fall", lcd_data, exp_q[0].data);
            end
            if (ack !== ack_prev) begin
                ack_cnt <= ack_cnt + 1;
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_ack");
                end else begin
                    chk("ack_time", cyc, exp_q[0].endc);
                    void'(exp_q.pop_front());
                end
            end
        end
        en_prev  <= lcd_en;
        ack_prev <= ack;
    end

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          seen;
        int          n, gap, base_ack, target;
        logic [31:0] r;
        logic        rs_v;
        logic [7:0]  d_v;

        // Reset: toggle bit 30 while in reset; release must not start a command
        rst = 1'b1;
        repeat (3) @(negedge clk);
        reg_v[30] = 1'b1;
        @(negedge clk);
        reg_v[30] = 1'b0;
        @(negedge clk);
        reg_v[30] = 1'b1;
        @(negedge clk);
        chk("reset_outputs", {lcd_on, lcd_en, lcd_rs, lcd_rw, lcd_data, busy, ack, ovf}, 0);
        rst  = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (lcd_en || busy || ack) seen = 1;
        end
        chk("no_cmd_after_reset", seen, 0);

        // ON bit: one clock of latency
        reg_v[31] = 1'b1;
        #1;
        chk("lcd_on_before_edge", lcd_on, 0);
        @(negedge clk);
        chk("lcd_on_after_edge", lcd_on, 1);

        // Reset in the middle of PULSE
        reg_v[9]   = 1'b1;
        reg_v[7:0] = 8'h55;
        reg_v[30]  = ~reg_v[30];
        n = 0;
        while (!lcd_en && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("en_reached", lcd_en, 1);
        @(negedge clk);
        chk("en_still_high", lcd_en, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("en_low_after_rst", {lcd_en, ack, busy, ovf}, 0);
        repeat (2) @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (lcd_en || busy || ack) seen = 1;
        end
        chk("no_cmd_after_mid_reset", seen, 0);
        chk("on_after_mid_reset", lcd_on, 1);

        mon_en = 1;

        // Data write and clear command
        do_req(1'b1, 8'h41);
        drain();
        do_req(1'b0, 8'h01);
        drain();
        do_req(1'b0, 8'h02);
        drain();

        // Request detected in the last WAIT clock
        do_req(1'b1, 8'h10);
        target = m_last_end;
        while (cyc + 1 < target) @(negedge clk);
        do_req(1'b1, 8'h5A);
        drain();
        chk("ovf_after_last_wait", ovf, 0);

        // Three requests one clock apart
        base_ack = ack_cnt;
        do_req(1'b1, 8'h31);
        do_req(1'b1, 8'h32);
        do_req(1'b1, 8'h33);
        chk("ovf_set", ovf, m_ovf);
        drain();
        chk("ack_count_triple", ack_cnt - base_ack, 2);

        // Random traffic
        repeat (60) begin
            gap = $urandom_range(0, 20);
            repeat (gap) @(negedge clk);
            r = $urandom;
            if (r[1:0] == 2'd0) begin
                rs_v = 1'b0;
                d_v  = r[2] ? 8'h01 : 8'h02;
            end else begin
                rs_v = r[3];
                d_v  = r[15:8];
            end
            do_req(rs_v, d_v);
        end
        drain();
        chk("ovf_final", ovf, m_ovf);
        chk("rw_final", lcd_rw, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
